// File: rtl/ps2_move_decoder_pkg.sv
// Shared scan-code constants, key bit indices, move codes and FSM state type
// for the PS/2 move decoder slice.
package ps2_move_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam int NUM_KEYS = 5;

  // Bit positions inside held/sticky: {action,right,left,down,up}
  localparam int KEY_UP     = 0;
  localparam int KEY_DOWN   = 1;
  localparam int KEY_LEFT   = 2;
  localparam int KEY_RIGHT  = 3;
  localparam int KEY_ACTION = 4;

  localparam logic [2:0] MOVE_NONE   = 3'b000;
  localparam logic [2:0] MOVE_UP     = 3'b001;
  localparam logic [2:0] MOVE_DOWN   = 3'b010;
  localparam logic [2:0] MOVE_LEFT   = 3'b011;
  localparam logic [2:0] MOVE_RIGHT  = 3'b100;
  localparam logic [2:0] MOVE_ACTION = 3'b101;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  function automatic logic [2:0] encode_move(input logic [NUM_KEYS-1:0] req);
    if (req[KEY_UP])          return MOVE_UP;
    else if (req[KEY_DOWN])   return MOVE_DOWN;
    else if (req[KEY_LEFT])   return MOVE_LEFT;
    else if (req[KEY_RIGHT])  return MOVE_RIGHT;
    else if (req[KEY_ACTION]) return MOVE_ACTION;
    else                      return MOVE_NONE;
  endfunction

endpackage

// File: rtl/ps2_move_decoder_if.sv
// Byte/frame inputs and move/status outputs between ps2_rx, the decoder
// and the collision detector.
interface ps2_move_decoder_if;
  import ps2_move_decoder_pkg::*;

  logic                rx_done_tick;
  logic [7:0]          rx_data;
  logic                frame_tick;
  logic [2:0]          move;
  logic                move_valid;
  logic [NUM_KEYS-1:0] held;
  logic [7:0]          last_code;

  modport master (
    output rx_done_tick, rx_data, frame_tick,
    input  move, move_valid, held, last_code
  );

  modport slave (
    input  rx_done_tick, rx_data, frame_tick,
    output move, move_valid, held, last_code
  );

endinterface

// File: rtl/ps2_move_decoder_key_lookup.sv
// Combinational scan-code to one-hot key map; zero for unmapped codes.
// Non-extended 75/72/6B/74 are keypad codes and deliberately unmapped.
module ps2_key_lookup
  import ps2_move_decoder_pkg::*;
#(
  parameter int ENABLE_WASD = 1
) (
  input  logic                ext,
  input  logic [7:0]          code,
  output logic [NUM_KEYS-1:0] key
);

  always_comb begin
    key = '0;
    if (ext) begin
      case (code)
        SC_UP:    key[KEY_UP]    = 1'b1;
        SC_DOWN:  key[KEY_DOWN]  = 1'b1;
        SC_LEFT:  key[KEY_LEFT]  = 1'b1;
        SC_RIGHT: key[KEY_RIGHT] = 1'b1;
        default:  key = '0;
      endcase
    end else begin
      case (code)
        SC_SPACE: key[KEY_ACTION] = 1'b1;
        SC_W:     key[KEY_UP]     = (ENABLE_WASD != 0);
        SC_S:     key[KEY_DOWN]   = (ENABLE_WASD != 0);
        SC_A:     key[KEY_LEFT]   = (ENABLE_WASD != 0);
        SC_D:     key[KEY_RIGHT]  = (ENABLE_WASD != 0);
        default:  key = '0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes, per-key held/sticky state and
// emits one prioritised move code per frame tick.
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int ENABLE_WASD    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  ps2_move_decoder_if.slave    bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t          state, state_nxt;
  logic [CNT_W-1:0]    timeout_cnt;
  logic [NUM_KEYS-1:0] held, sticky;
  logic [NUM_KEYS-1:0] key, make_mask, brk_mask;
  logic [7:0]          last_code;
  logic                key_ext, is_make, is_break;
  logic [2:0]          move_p0;
  logic                vld_p0;

  ps2_key_lookup #(.ENABLE_WASD(ENABLE_WASD)) u_lookup (
    .ext  (key_ext),
    .code (bus.rx_data),
    .key  (key)
  );

  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_break  = 1'b0;
    key_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
    if (bus.rx_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (bus.rx_data == SC_EXT)      state_nxt = ST_EXT;
          else if (bus.rx_data == SC_BRK) state_nxt = ST_BRK;
          else                            is_make   = 1'b1;
        end
        ST_EXT: begin
          if (bus.rx_data == SC_BRK)      state_nxt = ST_EXT_BRK;
          else if (bus.rx_data == SC_EXT) state_nxt = ST_EXT;
          else begin
            is_make   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          is_break  = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && timeout_cnt == CNT_LAST) begin
      // Abandoned prefix: drop it without touching any key state
      state_nxt = ST_IDLE;
    end
  end

  assign make_mask = is_make  ? key : '0;
  assign brk_mask  = is_break ? key : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      timeout_cnt <= '0;
      held        <= '0;
      sticky      <= '0;
      last_code   <= '0;
    end else begin
      state <= state_nxt;
      if (bus.rx_done_tick)
        timeout_cnt <= '0;
      else if (state != ST_IDLE && timeout_cnt != CNT_LAST)
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      if (bus.rx_done_tick && bus.rx_data != SC_EXT && bus.rx_data != SC_BRK)
        last_code <= bus.rx_data;
      held   <= (held | make_mask) & ~brk_mask;
      // A make landing on a frame tick survives the clear and reports next frame
      sticky <= (sticky & ~{NUM_KEYS{bus.frame_tick}}) | make_mask;
    end
  end

  // Stage p0: frame sample of pre-byte held|sticky, prioritised to one move code
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      move_p0 <= MOVE_NONE;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= bus.frame_tick;
      if (bus.frame_tick)
        move_p0 <= encode_move(held | sticky);
    end
  end

  assign bus.move       = move_p0;
  assign bus.move_valid = vld_p0;
  assign bus.held       = held;
  assign bus.last_code  = last_code;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Bench for ps2_move_decoder: directed table, hand-written corner sequences and
// random byte streams against a prefix-flag reference model.
module tb_ps2_move_decoder;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic resetn;

  ps2_move_decoder_if bus();

  ps2_move_decoder #(.TIMEOUT_CYCLES(TO), .ENABLE_WASD(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_ext, m_brk;
  logic [4:0] m_held, m_sticky;
  logic [2:0] m_move;
  bit         m_vld;
  logic [7:0] m_lc;
  int         cyc, last_rx_cyc;

  typedef struct {
    bit         rx;
    logic [7:0] d;
    bit         ft;
    bit         chk;
    logic [2:0] mv;
    bit         vld;
    logic [4:0] held;
    logic [7:0] lc;
  } vec_t;

  vec_t tbl[$];

  // Held bit order {action,right,left,down,up}
  function automatic logic [4:0] ref_key(input bit ext, input logic [7:0] c);
    if (ext) begin
      case (c)
        8'h75: return 5'b00001;
        8'h72: return 5'b00010;
        8'h6B: return 5'b00100;
        8'h74: return 5'b01000;
        default: return 5'b00000;
      endcase
    end
    case (c)
      8'h1D: return 5'b00001;
      8'h1B: return 5'b00010;
      8'h1C: return 5'b00100;
      8'h23: return 5'b01000;
      8'h29: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // Lowest set bit wins; move code is its index plus one
  function automatic logic [2:0] ref_move(input logic [4:0] r);
    for (int i = 0; i < 5; i++)
      if (r[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = '0; m_sticky = '0;
    m_move = '0; m_vld = 0; m_lc = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".move"},       32'(bus.move),       32'(m_move));
    check({tag, ".move_valid"}, 32'(bus.move_valid), 32'(m_vld));
    check({tag, ".held"},       32'(bus.held),       32'(m_held));
    check({tag, ".last_code"},  32'(bus.last_code),  32'(m_lc));
  endtask

  task automatic step(input bit rx, input logic [7:0] d, input bit ft);
    logic [4:0] mk, bk;
    mk = '0; bk = '0;
    bus.rx_done_tick = rx;
    bus.rx_data      = d;
    bus.frame_tick   = ft;
    m_vld = ft;
    if (ft) m_move = ref_move(m_held | m_sticky);
    if (rx) begin
      if ((m_ext || m_brk) && (cyc - last_rx_cyc > TO)) begin
        m_ext = 0; m_brk = 0;
      end
      last_rx_cyc = cyc;
      if (d != 8'hE0 && d != 8'hF0) m_lc = d;
      if (m_brk) begin
        bk = ref_key(m_ext, d);
        m_ext = 0; m_brk = 0;
      end else if (d == 8'hF0) m_brk = 1;
      else if (d == 8'hE0) m_ext = 1;
      else begin
        mk = ref_key(m_ext, d);
        m_ext = 0;
      end
    end
    m_sticky = (ft ? 5'b0 : m_sticky) | mk;
    m_held   = (m_held | mk) & ~bk;
    @(posedge clk);
    #1;
    cyc++;
    bus.rx_done_tick = 1'b0;
    bus.frame_tick   = 1'b0;
    check_outputs("model");
  endtask

  task automatic add(input bit rx, input logic [7:0] d, input bit ft, input bit chk,
                     input logic [2:0] mv, input bit vld, input logic [4:0] h,
                     input logic [7:0] lc);
    vec_t v;
    v.rx = rx; v.d = d; v.ft = ft; v.chk = chk;
    v.mv = mv; v.vld = vld; v.held = h; v.lc = lc;
    tbl.push_back(v);
  endtask

  task automatic do_reset_pulse();
    resetn = 1'b0;
    #2;
    model_reset();
    check("rst.move",       32'(bus.move),       32'd0);
    check("rst.move_valid", 32'(bus.move_valid), 32'd0);
    check("rst.held",       32'(bus.held),       32'd0);
    check("rst.last_code",  32'(bus.last_code),  32'd0);
    @(posedge clk);
    #1;
    cyc++;
    resetn = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] code, input bit ext, input bit brk);
    if (ext) step(1, 8'hE0, 0);
    if (brk) step(1, 8'hF0, 0);
    step(1, code, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.frame_tick   = 1'b0;
    resetn = 1'b0;
    cyc = 0; last_rx_cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.move",       32'(bus.move),       32'd0);
    check("reset.move_valid", 32'(bus.move_valid), 32'd0);
    check("reset.held",       32'(bus.held),       32'd0);
    check("reset.last_code",  32'(bus.last_code),  32'd0);
    resetn = 1'b1;

    // rx, data, ft, chk, move, valid, held, last_code
    add(1, 8'h1D, 0, 1, 3'd0, 0, 5'h01, 8'h1D);
    add(0, 8'h00, 1, 1, 3'd1, 1, 5'h01, 8'h1D);
    add(0, 8'h00, 0, 1, 3'd1, 0, 5'h01, 8'h1D);
    add(1, 8'hF0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h1D, 0, 1, 3'd1, 0, 5'h00, 8'h1D);
    add(0, 8'h00, 1, 1, 3'd0, 1, 5'h00, 8'h1D);
    add(1, 8'hE0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h74, 0, 1, 3'd0, 0, 5'h08, 8'h74);
    add(0, 8'h00, 1, 1, 3'd4, 1, 5'h08, 8'h74);
    add(0, 8'h00, 1, 1, 3'd4, 1, 5'h08, 8'h74);
    add(1, 8'hE0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'hF0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h74, 0, 1, 3'd4, 0, 5'h00, 8'h74);
    add(0, 8'h00, 1, 1, 3'd0, 1, 5'h00, 8'h74);
    add(1, 8'hE0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h75, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'hE0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h6B, 0, 1, 3'd0, 0, 5'h05, 8'h6B);
    add(0, 8'h00, 1, 1, 3'd1, 1, 5'h05, 8'h6B);
    add(1, 8'hE0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'hF0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h75, 0, 1, 3'd1, 0, 5'h04, 8'h75);
    add(0, 8'h00, 1, 1, 3'd3, 1, 5'h04, 8'h75);
    add(1, 8'hE0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'hF0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h6B, 0, 1, 3'd3, 0, 5'h00, 8'h6B);
    add(0, 8'h00, 1, 1, 3'd0, 1, 5'h00, 8'h6B);
    add(1, 8'h29, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'hF0, 0, 0, 3'd0, 0, 5'h00, 8'h00);
    add(1, 8'h29, 0, 1, 3'd0, 0, 5'h00, 8'h29);
    add(0, 8'h00, 1, 1, 3'd5, 1, 5'h00, 8'h29);
    add(0, 8'h00, 1, 1, 3'd0, 1, 5'h00, 8'h29);
    add(1, 8'h75, 0, 1, 3'd0, 0, 5'h00, 8'h75);
    add(0, 8'h00, 1, 1, 3'd0, 1, 5'h00, 8'h75);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rx, tbl[i].d, tbl[i].ft);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d.move", i),       32'(bus.move),       32'(tbl[i].mv));
        check($sformatf("vec%0d.move_valid", i), 32'(bus.move_valid), 32'(tbl[i].vld));
        check($sformatf("vec%0d.held", i),       32'(bus.held),       32'(tbl[i].held));
        check($sformatf("vec%0d.last_code", i),  32'(bus.last_code),  32'(tbl[i].lc));
      end
    end

    // Prefix abandoned: 75 after the timeout is a keypad (non-ext) code
    step(1, 8'hE0, 0);
    repeat (TO) step(0, 8'h00, 0);
    step(1, 8'h75, 0);
    check("timeout.held", 32'(bus.held), 32'h00);
    send_key(8'h75, 1, 0);
    check("timeout.idle_after", 32'(bus.held), 32'h01);
    send_key(8'h75, 1, 1);
    // Prefix still live just inside the window
    step(1, 8'hE0, 0);
    repeat (TO - 2) step(0, 8'h00, 0);
    step(1, 8'h75, 0);
    check("timeout.inside.held", 32'(bus.held), 32'h01);
    send_key(8'h75, 1, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);

    // Byte coincident with frame tick is reported the following frame
    step(1, 8'h1D, 1);
    check("coincide.move1",  32'(bus.move),       32'd0);
    check("coincide.valid1", 32'(bus.move_valid), 32'd1);
    check("coincide.held",   32'(bus.held),       32'h01);
    step(0, 8'h00, 1);
    check("coincide.move2",  32'(bus.move),       32'd1);
    send_key(8'h1D, 0, 1);
    step(0, 8'h00, 1);

    // Reset mid-sequence discards the pending break prefix
    step(1, 8'hF0, 0);
    do_reset_pulse();
    step(1, 8'h1D, 0);
    check("rstseq.held", 32'(bus.held), 32'h01);
    send_key(8'h1D, 0, 1);

    // Random byte streams, frames and long gaps
    for (int n = 0; n < 150; n++) begin
      logic [7:0] codes [10];
      logic [7:0] c;
      int kind;
      codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h12};
      c = codes[$urandom_range(0, 9)];
      kind = $urandom_range(0, 9);
      if (kind < 8) begin
        if (kind[0]) step(1, 8'hE0, $urandom_range(0, 5) == 0);
        if (kind[1]) step(1, 8'hF0, $urandom_range(0, 5) == 0);
        step(1, c, $urandom_range(0, 5) == 0);
      end else if (kind == 8) begin
        step(1, ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0, 0);
        repeat (TO + 5) step(0, 8'($urandom), 0);
      end else begin
        step(0, 8'($urandom), 1);
      end
      repeat ($urandom_range(0, 3)) step(0, 8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
